shape_edit_arbiter: RTL

- Serialises shape-property edits from NREQ independent requesters into the shape property table.
- Typical requesters: button UI FSM, colour picker, add/remove logic, animation engine.
- Edits are committed only inside a per-frame window opened by the VGA frame pulse, so the renderer never sees a half-updated shape mid-scan.
- Sits between the control FSMs and the shape register array; it owns the single write port.

---
 rtl/shape_edit_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/shape_edit_arbiter.sv
// shape_edit_arbiter: serialises shape-property edits from NREQ requesters
// into the single write port of the shape property table. Edits are only
// accepted inside a per-frame commit window opened by the frame pulse, so the
// renderer never scans a half-updated shape.
// Optional build macro: SHAPE_EDIT_PRIO0_EN gives requester 0 fixed top
// priority; the other requesters keep round-robin among themselves.
module shape_edit_arbiter #(
  parameter int NREQ   = 4,
  parameter int MAXSHP = 4,
  parameter int DATAW  = 16,
  parameter int BUDGET = 8,
  parameter int WINLEN = 64,
  localparam int IDW   = (MAXSHP > 1) ? $clog2(MAXSHP) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*IDW-1:0]   req_id,
  input  logic [NREQ*3-1:0]     req_field,
  input  logic [NREQ*DATAW-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  wr_en,
  output logic [IDW-1:0]        wr_id,
  output logic [2:0]            wr_field,
  output logic [DATAW-1:0]      wr_data,
  output logic                  window,
  output logic                  err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(BUDGET + 1);
  localparam int TW = (WINLEN > 1) ? $clog2(WINLEN) : 1;

  typedef enum logic [1:0] {IDLE, WINDOW, CLOSE} state_t;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [2:0]       field;
    logic [DATAW-1:0] data;
  } edit_t;

  state_t               state, state_nx;
  logic [PW-1:0]        ptr, gnt_idx, idx;
  logic                 gnt_any, grant;
  logic [BW-1:0]        budget;
  logic [TW-1:0]        timer;
  edit_t [NREQ-1:0]     lane_req;
  logic [NREQ-1:0]      bad;
  edit_t                sel;

  // Per-lane unpack and bad-request detect (slot out of range or reserved field).
  for (genvar k = 0; k < NREQ; k++) begin : g_lane
    assign lane_req[k] = {req_id[k*IDW +: IDW], req_field[k*3 +: 3], req_data[k*DATAW +: DATAW]};
    assign bad[k] = ({1'b0, lane_req[k].id} >= (IDW+1)'(MAXSHP)) ||
                    (lane_req[k].field[2:1] == 2'b11);
  end

  // Round-robin pick: first valid index at or after ptr, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
`ifdef SHAPE_EDIT_PRIO0_EN
    if (req_valid[0]) gnt_any = 1'b1;
`endif
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
`ifdef SHAPE_EDIT_PRIO0_EN
      if (!gnt_any && idx != '0 && req_valid[idx]) begin
`else
      if (!gnt_any && req_valid[idx]) begin
`endif
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // No transfers outside the window, and none on a reset cycle.
  assign grant  = (state == WINDOW) && gnt_any && !rst;
  assign sel    = lane_req[gnt_idx];
  assign window = (state == WINDOW);

  // One-hot ready for the chosen lane.
  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NREQ; k++)
      req_ready[k] = grant && (gnt_idx == PW'(k));
  end

  // Window sequencing: close on budget exhaustion, timeout, or idle after the first cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (frame) state_nx = WINDOW;
      WINDOW: if ((timer == '0) ||
                  (grant && budget <= BW'(1)) ||
                  (!(|req_valid) && timer != TW'(WINLEN - 1)))
                state_nx = CLOSE;
      CLOSE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Budget and timer: loaded on window open, counted down inside the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      budget <= '0;
      timer  <= '0;
    end else if (state == IDLE && frame) begin
      budget <= BW'(BUDGET);
      timer  <= TW'(WINLEN - 1);
    end else if (state == WINDOW) begin
      if (timer != '0) timer <= timer - 1'b1;
      if (grant && budget != '0) budget <= budget - 1'b1;
    end
  end

  // Round-robin pointer; survives across windows.
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
`ifdef SHAPE_EDIT_PRIO0_EN
    else if (grant && gnt_idx != '0)
`else
    else if (grant)
`endif
      ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Write port: one-cycle latency, bad requests are drained but not written.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_id    <= '0;
      wr_field <= '0;
      wr_data  <= '0;
      err      <= 1'b0;
    end else begin
      wr_en <= grant && !bad[gnt_idx];
      if (grant && !bad[gnt_idx]) begin
        wr_id    <= sel.id;
        wr_field <= sel.field;
        wr_data  <= sel.data;
      end
      if (grant && bad[gnt_idx]) err <= 1'b1;
    end
  end

endmodule
